dual_port_ram_lat: RTL and testbench

True dual-port synchronous RAM with two independent read/write ports (A and B) sharing one clock. Each port has parameterizable, fixed read and write pipeline latencies. The block is the general-purpose buffer memory for datapaths that need two concurrent accessors at pipelined timing.

---
 rtl/dual_port_ram_lat.sv | 83 ++++++++
 tb/tb_dual_port_ram_lat.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/dual_port_ram_lat.sv
// dual_port_ram_lat: true dual-port RAM, two independent ports with fixed
// per-port read and write pipeline latencies; port B wins same-edge commits.
module dual_port_ram_lat #(
   parameter int ADDR_WIDTH    = 4,
   parameter int DATA_WIDTH    = 8,
   parameter int READ_LATENCY  = 3,
   parameter int WRITE_LATENCY = 3
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [DATA_WIDTH-1:0] i_dina,
   input  logic [ADDR_WIDTH-1:0] i_addra,
   input  logic                  i_ena,
   input  logic                  i_wea,
   output logic [DATA_WIDTH-1:0] o_douta,
   input  logic [DATA_WIDTH-1:0] i_dinb,
   input  logic [ADDR_WIDTH-1:0] i_addrb,
   input  logic                  i_enb,
   input  logic                  i_web,
   output logic [DATA_WIDTH-1:0] o_doutb
);
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam int WS    = (WRITE_LATENCY > 1) ? WRITE_LATENCY - 1 : 1;
   localparam int RS    = (READ_LATENCY > 1) ? READ_LATENCY - 1 : 1;

   typedef struct packed {
      logic                  v;
      logic [ADDR_WIDTH-1:0] a;
      logic [DATA_WIDTH-1:0] d;
   } wr_t;

   typedef struct packed {
      logic                  v;
      logic [DATA_WIDTH-1:0] d;
   } rd_t;

   logic [DATA_WIDTH-1:0] mem_q  [DEPTH];
   wr_t                   wr_q   [2][WS];
   rd_t                   rd_q   [2][RS];
   logic [DATA_WIDTH-1:0] dout_q [2];
   logic [DATA_WIDTH-1:0] dout_d [2];
   wr_t                   wr_in  [2];
   wr_t                   wr_cmt [2];
   rd_t                   rd_in  [2];
   rd_t                   rd_out [2];

   // Latency 1 bypasses the stage registers: commit/output straight from the request.
   always_comb begin
      wr_in[0] = {i_ena & i_wea, i_addra, i_dina};
      wr_in[1] = {i_enb & i_web, i_addrb, i_dinb};
      rd_in[0] = {i_ena & ~i_wea, mem_q[i_addra]};
      rd_in[1] = {i_enb & ~i_web, mem_q[i_addrb]};
      for (int p = 0; p < 2; p++) begin
         wr_cmt[p] = (WRITE_LATENCY == 1) ? wr_in[p] : wr_q[p][WS-1];
         rd_out[p] = (READ_LATENCY == 1) ? rd_in[p] : rd_q[p][RS-1];
         dout_d[p] = rd_out[p].v ? rd_out[p].d : dout_q[p];
      end
   end

   // Port loop runs A then B so B's commit is the last assignment on collision.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         for (int p = 0; p < 2; p++) begin
            dout_q[p] <= '0;
            for (int i = 0; i < WS; i++) wr_q[p][i] <= '0;
            for (int i = 0; i < RS; i++) rd_q[p][i] <= '0;
         end
      end else begin
         for (int p = 0; p < 2; p++) begin
            if (wr_cmt[p].v) mem_q[wr_cmt[p].a] <= wr_cmt[p].d;
            wr_q[p][0] <= wr_in[p];
            rd_q[p][0] <= rd_in[p];
            for (int i = 1; i < WS; i++) wr_q[p][i] <= wr_q[p][i-1];
            for (int i = 1; i < RS; i++) rd_q[p][i] <= rd_q[p][i-1];
            dout_q[p] <= dout_d[p];
         end
      end
   end

   assign o_douta = dout_q[0];
   assign o_doutb = dout_q[1];
endmodule

// File: tb/tb_dual_port_ram_lat.sv
// tb_dual_port_ram_lat: directed scenarios plus randomized traffic checked
// against an event-scheduled memory model (commit/return due edges).
module tb_dual_port_ram_lat;
   localparam int RL = 3;
   localparam int WL = 3;

   logic       clk = 0;
   logic       rst;
   logic [7:0] dina, dinb, douta, doutb;
   logic [3:0] addra, addrb;
   logic       ena, wea, enb, web;

   dual_port_ram_lat #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .READ_LATENCY(RL), .WRITE_LATENCY(WL)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_dina(dina), .i_addra(addra), .i_ena(ena), .i_wea(wea), .o_douta(douta),
      .i_dinb(dinb), .i_addrb(addrb), .i_enb(enb), .i_web(web), .o_doutb(doutb)
   );

   always #5 clk = ~clk;

   typedef struct {int due; bit p; logic [3:0] a; logic [7:0] d;} wr_e;
   typedef struct {int due; bit p; logic [7:0] d;} rd_e;

   logic [7:0] mm [16];
   wr_e        pw [$];
   rd_e        pr [$];
   logic [7:0] exp_a, exp_b;
   int         cyc = 0;
   int         errors = 0;
   int         checks = 0;

   // One edge: drive, clock, then advance the model (reads see pre-edge memory).
   task automatic step(input logic ea, wa, input logic [3:0] aa, input logic [7:0] da,
                       input logic eb, wb, input logic [3:0] ab, input logic [7:0] db,
                       input logic r);
      wr_e wk [$];
      rd_e rk [$];
      ena = ea; wea = wa; addra = aa; dina = da;
      enb = eb; web = wb; addrb = ab; dinb = db;
      rst = r;
      @(posedge clk);
      if (r) begin
         pw.delete(); pr.delete();
         foreach (mm[i]) mm[i] = 8'h00;
         exp_a = 8'h00; exp_b = 8'h00;
      end else begin
         if (ea && !wa) pr.push_back('{cyc + RL - 1, 1'b0, mm[aa]});
         if (eb && !wb) pr.push_back('{cyc + RL - 1, 1'b1, mm[ab]});
         if (ea && wa) pw.push_back('{cyc + WL - 1, 1'b0, aa, da});
         if (eb && wb) pw.push_back('{cyc + WL - 1, 1'b1, ab, db});
         foreach (pw[i]) if (pw[i].due == cyc) mm[pw[i].a] = pw[i].d; else wk.push_back(pw[i]);
         pw = wk;
         foreach (pr[i]) begin
            if (pr[i].due != cyc) rk.push_back(pr[i]);
            else if (pr[i].p) exp_b = pr[i].d;
            else exp_a = pr[i].d;
         end
         pr = rk;
      end
      cyc++;
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00, 0);
   endtask

   task automatic test_reset();
      step(0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00, 1);
      step(1, 1, 4'h5, 8'hEE, 1, 1, 4'h6, 8'hDD, 1);
      checks++; if (douta !== 8'h00) begin errors++; $display("FAIL reset_douta: got %h want 00", douta); end
      checks++; if (doutb !== 8'h00) begin errors++; $display("FAIL reset_doutb: got %h want 00", doutb); end
      step(1, 0, 4'hF, 8'h00, 1, 0, 4'h5, 8'h00, 0);
      idle(RL - 1);
      checks++; if (douta !== 8'h00) begin errors++; $display("FAIL reset_read_f: got %h want 00", douta); end
      checks++; if (doutb !== 8'h00) begin errors++; $display("FAIL reset_ignored_write: got %h want 00", doutb); end
   endtask

   task automatic test_raw();
      step(1, 1, 4'h3, 8'hA5, 0, 0, 4'h0, 8'h00, 0);
      idle(1);
      step(1, 0, 4'h3, 8'h00, 0, 0, 4'h0, 8'h00, 0);
      step(1, 0, 4'h3, 8'h00, 0, 0, 4'h0, 8'h00, 0);
      idle(1);
      checks++; if (douta !== 8'h00) begin errors++; $display("FAIL raw_early_read: got %h want 00", douta); end
      idle(1);
      checks++; if (douta !== 8'hA5) begin errors++; $display("FAIL raw_read: got %h want a5", douta); end
      checks++; if (douta !== exp_a) begin errors++; $display("FAIL raw_model: got %h want %h", douta, exp_a); end
   endtask

   task automatic test_cross_port();
      step(0, 0, 4'h0, 8'h00, 1, 0, 4'h3, 8'h00, 0);
      step(0, 0, 4'h0, 8'h00, 1, 1, 4'hF, 8'h3C, 0);
      idle(2);
      step(1, 0, 4'hF, 8'h00, 0, 0, 4'h0, 8'h00, 0);
      idle(RL - 1);
      checks++; if (douta !== 8'h3C) begin errors++; $display("FAIL cross_douta: got %h want 3c", douta); end
      checks++; if (doutb !== 8'hA5) begin errors++; $display("FAIL cross_doutb_held: got %h want a5", doutb); end
   endtask

   task automatic test_collision();
      step(1, 1, 4'h7, 8'h11, 1, 1, 4'h7, 8'h22, 0);
      idle(WL - 1);
      step(1, 0, 4'h7, 8'h00, 1, 0, 4'h7, 8'h00, 0);
      idle(RL - 1);
      checks++; if (douta !== 8'h22) begin errors++; $display("FAIL collision_a: got %h want 22", douta); end
      checks++; if (doutb !== 8'h22) begin errors++; $display("FAIL collision_b: got %h want 22", doutb); end
   endtask

   task automatic test_reset_mid();
      step(1, 1, 4'h2, 8'h55, 1, 0, 4'h7, 8'h00, 0);
      step(1, 0, 4'h7, 8'h00, 0, 0, 4'h0, 8'h00, 1);
      checks++; if (doutb !== 8'h00) begin errors++; $display("FAIL mid_reset_doutb: got %h want 00", doutb); end
      for (int i = 0; i < 3; i++) begin
         idle(1);
         checks++; if (douta !== 8'h00 || doutb !== 8'h00) begin errors++; $display("FAIL mid_reset_stale: got %h/%h want 00/00", douta, doutb); end
      end
      step(1, 0, 4'h2, 8'h00, 1, 0, 4'h7, 8'h00, 0);
      idle(RL - 1);
      checks++; if (douta !== 8'h00) begin errors++; $display("FAIL mid_reset_addr2: got %h want 00", douta); end
      checks++; if (doutb !== 8'h00) begin errors++; $display("FAIL mid_reset_addr7: got %h want 00", doutb); end
   endtask

   task automatic test_streaming();
      for (int i = 0; i < 16; i++) step(1, 1, 4'(i), 8'(i) ^ 8'h80, 0, 0, 4'h0, 8'h00, 0);
      for (int i = 0; i < 16 + RL - 1; i++) begin
         if (i < 16) step(1, 0, 4'(i), 8'h00, 0, 0, 4'h0, 8'h00, 0);
         else idle(1);
         if (i >= RL - 1) begin
            checks++;
            if (douta !== (8'h80 | 8'(i - RL + 1))) begin
               errors++; $display("FAIL stream[%0d]: got %h want %h", i - RL + 1, douta, 8'h80 | 8'(i - RL + 1));
            end
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         logic sm;
         sm = 1'($urandom);
         step(1'($urandom_range(0, 3) != 0), 1'($urandom), sm ? 4'($urandom_range(0, 3)) : 4'($urandom), 8'($urandom),
              1'($urandom_range(0, 3) != 0), 1'($urandom), sm ? 4'($urandom_range(0, 3)) : 4'($urandom), 8'($urandom),
              $urandom_range(0, 59) == 0);
         checks++; if (douta !== exp_a) begin errors++; $display("FAIL rand_a cyc %0d: got %h want %h", cyc, douta, exp_a); end
         checks++; if (doutb !== exp_b) begin errors++; $display("FAIL rand_b cyc %0d: got %h want %h", cyc, doutb, exp_b); end
      end
   endtask

   initial begin
      rst = 1; ena = 0; wea = 0; enb = 0; web = 0;
      addra = '0; addrb = '0; dina = '0; dinb = '0;
      test_reset();
      test_raw();
      test_cross_port();
      test_collision();
      test_reset_mid();
      test_streaming();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
